// File: rtl/batcharger_ctrl_fsm_if.sv
// batcharger_ctrl_fsm_if: ADC-sample / DAC-setpoint bundle between the charger
// front-end (master) and the charge controller (slave).
interface batcharger_ctrl_fsm_if #(
   parameter int ADC_W = 10,
   parameter int DAC_W = 10
);
   logic             en;
   logic [3:0]       sel;
   logic             smp_vld;
   logic [ADC_W-1:0] vbat;
   logic [ADC_W-1:0] ibat;
   logic [ADC_W-1:0] vtemp;
   logic [ADC_W-1:0] vcutoff;
   logic [ADC_W-1:0] vtarget;
   logic [ADC_W-1:0] tmin;
   logic [ADC_W-1:0] tmax;
   logic [DAC_W-1:0] iref;
   logic [DAC_W-1:0] vref;
   logic             tc;
   logic             cc;
   logic             cv;
   logic             done;
   logic             fault;
   modport master (
      output en, sel, smp_vld, vbat, ibat, vtemp, vcutoff, vtarget, tmin, tmax,
      input  iref, vref, tc, cc, cv, done, fault
   );
   modport slave (
      input  en, sel, smp_vld, vbat, ibat, vtemp, vcutoff, vtarget, tmin, tmax,
      output iref, vref, tc, cc, cv, done, fault
   );
endinterface

// File: rtl/batcharger_ctrl_fsm.sv
// batcharger_ctrl_fsm: Li-ion charge sequencer IDLE->TC->CC->CV->DONE with temperature/timeout faults.
// Optional BATCHG_RECHARGE_EN: DONE re-enters CC when vbat sags below vtarget - vtarget/32.
module batcharger_ctrl_fsm #(
   parameter int          ADC_W    = 10,
   parameter int          DAC_W    = 10,
   parameter int          DEB_CYC  = 4,
   parameter int          TMR_W    = 24,
   parameter int unsigned TC_TMAX  = 2**20,
   parameter int unsigned CHG_TMAX = 2**23
) (
   input logic                  clk,
   input logic                  rstz,
   batcharger_ctrl_fsm_if.slave bus
);
   localparam int unsigned DAC_MAX = (1 << DAC_W) - 1;
   typedef enum logic [2:0] {IDLE, TC, CC, CV, DONE, FAULT} state_t;
   state_t           state_q, state_d, thr_next;
   logic [7:0]       deb_q, deb_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [DAC_W-1:0] iref_q, vref_q, icc, itc, iterm;
   logic             tc_q, cc_q, cv_q, done_q, fault_q;
   logic [15:0]      icc_w;
   logic             active, temp_bad, timeout, rech, qual, deb_hit;
   assign icc_w = 16'd50 * (16'(bus.sel) + 16'd1);
   assign icc   = 32'(icc_w) > DAC_MAX ? DAC_W'(DAC_MAX) : DAC_W'(icc_w);
   assign itc   = icc >> 3;
   assign iterm = icc >> 4;
`ifdef BATCHG_RECHARGE_EN
   logic [ADC_W-1:0] vrech;
   assign vrech = bus.vtarget - (bus.vtarget >> 5);
   assign rech  = bus.vbat < vrech;
`else
   assign rech = 1'b0;
`endif
   // priority: en low > temperature > timeout > debounced threshold
   always_comb begin
      active   = state_q inside {TC, CC, CV};
      temp_bad = bus.vtemp < bus.tmin || bus.vtemp > bus.tmax;
      timeout  = state_q == TC ? 32'(timer_q) >= TC_TMAX : 32'(timer_q) >= CHG_TMAX;
      qual     = state_q == TC   ? bus.vbat >= bus.vcutoff :
                 state_q == CC   ? bus.vbat >= bus.vtarget :
                 state_q == CV   ? 32'(bus.ibat) <= 32'(iterm) :
                 state_q == DONE ? rech : 1'b0;
      thr_next = state_q == TC ? CC : state_q == CC ? CV : state_q == CV ? DONE : CC;
      deb_hit  = bus.smp_vld && qual && deb_q == 8'(DEB_CYC - 1);
      state_d  = !bus.en                           ? IDLE  :
                 state_q == IDLE                   ? TC    :
                 active && bus.smp_vld && temp_bad ? FAULT :
                 active && timeout                 ? FAULT :
                 deb_hit                           ? thr_next : state_q;
      deb_d    = !bus.en || state_d != state_q ? '0 :
                 bus.smp_vld ? (qual ? deb_q + 8'd1 : '0) : deb_q;
      // timer restarts on TC and CC entry only, so CC->CV keeps the combined budget
      timer_d  = !bus.en || (state_d != state_q && (state_d == TC || state_d == CC)) ? '0 :
                 active && timer_q != '1 ? timer_q + TMR_W'(1) : timer_q;
   end
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q <= IDLE;
         deb_q   <= '0;
         timer_q <= '0;
         iref_q  <= '0;
         vref_q  <= '0;
         tc_q    <= 1'b0;
         cc_q    <= 1'b0;
         cv_q    <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         timer_q <= timer_d;
         iref_q  <= state_d == TC ? itc : (state_d == CC || state_d == CV) ? icc : '0;
         vref_q  <= state_d inside {TC, CC, CV} ? DAC_W'(bus.vtarget) : '0;
         tc_q    <= state_d == TC;
         cc_q    <= state_d == CC;
         cv_q    <= state_d == CV;
         done_q  <= state_d == DONE;
         fault_q <= state_d == FAULT;
      end
   end
   assign bus.iref  = iref_q;
   assign bus.vref  = vref_q;
   assign bus.tc    = tc_q;
   assign bus.cc    = cc_q;
   assign bus.cv    = cv_q;
   assign bus.done  = done_q;
   assign bus.fault = fault_q;
endmodule

// File: tb/tb_batcharger_ctrl_fsm.sv
// tb_batcharger_ctrl_fsm: directed vector table plus hand sequences for reset, faults,
// timeouts and DONE behaviour (recharge expectation follows BATCHG_RECHARGE_EN).
module tb_batcharger_ctrl_fsm;
   localparam logic [4:0] ID = 5'b00000, TC = 5'b10000, CC = 5'b01000,
                          CV = 5'b00100, DN = 5'b00010, FL = 5'b00001;
   typedef struct {
      logic       en;
      logic       smp;
      logic [9:0] vbat;
      logic [9:0] ibat;
      logic [9:0] vtemp;
      logic [3:0] sel;
      logic [4:0] flg;
      logic [9:0] iref;
      logic [9:0] vref;
   } vec_t;
   logic clk = 1'b0;
   logic rstz = 1'b1;
   int   nvec = 0;
   int   nerr = 0;
   vec_t tbl[$];
   batcharger_ctrl_fsm_if #(.ADC_W(10), .DAC_W(10)) bus ();
   batcharger_ctrl_fsm #(.DEB_CYC(4), .TC_TMAX(100), .CHG_TMAX(200)) dut (
      .clk(clk), .rstz(rstz), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic drive(input logic en, input logic smp, input logic [9:0] vbat,
                        input logic [9:0] ibat, input logic [9:0] vtemp, input logic [3:0] sel);
      bus.en = en; bus.smp_vld = smp; bus.vbat = vbat;
      bus.ibat = ibat; bus.vtemp = vtemp; bus.sel = sel;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [4:0] f, input logic [9:0] ir, input logic [9:0] vr);
      logic [4:0] g;
      g = {bus.tc, bus.cc, bus.cv, bus.done, bus.fault};
      nvec++;
      if ({g, bus.iref, bus.vref} !== {f, ir, vr}) begin
         nerr++;
         $display("FAIL %s: got flags=%b iref=%0d vref=%0d, want flags=%b iref=%0d vref=%0d",
                  nm, g, bus.iref, bus.vref, f, ir, vr);
      end
   endtask
   task automatic add(input logic en, input logic smp, input logic [9:0] vbat, input logic [9:0] ibat,
                      input logic [9:0] vtemp, input logic [3:0] sel, input logic [4:0] flg,
                      input logic [9:0] iref, input logic [9:0] vref);
      vec_t v;
      v = '{en, smp, vbat, ibat, vtemp, sel, flg, iref, vref};
      tbl.push_back(v);
   endtask
   task automatic goto_cc();
      drive(0, 0, 0, 100, 500, 8); step();
      drive(1, 0, 0, 100, 500, 8); step();
      drive(1, 1, 600, 100, 500, 8);
      repeat (4) step();
      chk("goto_cc", CC, 450, 700);
   endtask
   initial begin
      drive(0, 0, 0, 100, 500, 8);
      bus.vcutoff = 500; bus.vtarget = 700; bus.tmin = 100; bus.tmax = 900;
      #1 rstz = 1'b0;
      #1 chk("reset", ID, 0, 0);
      #20 rstz = 1'b1;
      //   en smp vbat ibat vtemp sel  flags iref vref
      add(0, 0,   0, 100, 500,  8, ID,   0,   0);
      add(1, 0,   0, 100, 500,  8, TC,  56, 700);
      add(1, 1, 100, 100, 500,  8, TC,  56, 700);
      add(1, 1, 300, 100, 500,  8, TC,  56, 700);
      add(1, 1, 500, 100, 500,  8, TC,  56, 700);
      add(1, 1, 520, 100, 500,  8, TC,  56, 700);
      add(1, 0,   0, 100, 500,  8, TC,  56, 700);
      add(1, 1, 600, 100, 500,  8, TC,  56, 700);
      add(1, 1, 600, 100, 500,  8, CC, 450, 700);
      add(1, 1, 700, 100, 500,  8, CC, 450, 700);
      add(1, 1, 710, 100, 500,  8, CC, 450, 700);
      add(1, 1, 720, 100, 500,  8, CC, 450, 700);
      add(1, 1, 699, 100, 500,  8, CC, 450, 700);
      add(1, 1, 700, 100, 500,  8, CC, 450, 700);
      add(1, 1, 700, 100, 500,  8, CC, 450, 700);
      add(1, 1, 700, 100, 500,  8, CC, 450, 700);
      add(1, 1, 700, 100, 500,  8, CV, 450, 700);
      add(1, 1, 700, 100, 500,  3, CV, 200, 700);
      add(1, 1, 700, 100, 500,  8, CV, 450, 700);
      add(1, 1, 700,  28, 500,  8, CV, 450, 700);
      add(1, 1, 700,  28, 500,  8, CV, 450, 700);
      add(1, 1, 700,  28, 500,  8, CV, 450, 700);
      add(1, 1, 700,  28, 500,  8, DN,   0,   0);
      add(1, 1, 700,  28, 500,  8, DN,   0,   0);
      add(0, 0, 700,  28, 500,  8, ID,   0,   0);
      add(1, 0,   0, 100, 500, 15, TC, 100, 700);
      add(1, 1,   0, 100,  99, 15, FL,   0,   0);
      add(1, 1,   0, 100, 500, 15, FL,   0,   0);
      add(0, 0,   0, 100, 500,  0, ID,   0,   0);
      add(1, 0,   0, 100, 500,  0, TC,   6, 700);
      add(1, 1,   0, 100, 100,  0, TC,   6, 700);
      add(1, 1,   0, 100, 900,  0, TC,   6, 700);
      add(1, 1,   0, 100, 901,  0, FL,   0,   0);
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].smp, tbl[i].vbat, tbl[i].ibat, tbl[i].vtemp, tbl[i].sel);
         step();
         chk($sformatf("vec%0d", i), tbl[i].flg, tbl[i].iref, tbl[i].vref);
      end
      // async reset mid-CC, then restart
      goto_cc();
      #3 rstz = 1'b0;
      #1 chk("async_rst", ID, 0, 0);
      bus.en = 1'b0;
      #2 rstz = 1'b1;
      step(); chk("rst_idle", ID, 0, 0);
      bus.en = 1'b1;
      step(); chk("rst_tc", TC, 56, 700);
      // over-temperature in CC, cleared by en pulse
      goto_cc();
      drive(1, 1, 600, 100, 901, 8); step(); chk("cc_hot_fault", FL, 0, 0);
      drive(0, 0, 600, 100, 500, 8); step(); chk("fault_clr", ID, 0, 0);
      drive(1, 0, 600, 100, 500, 8); step(); chk("fault_restart", TC, 56, 700);
      // TC timeout
      drive(0, 0, 0, 100, 500, 8); step();
      drive(1, 1, 0, 100, 500, 8); step(); chk("tmo_tc_entry", TC, 56, 700);
      repeat (100) step();
      chk("tc_t100", TC, 56, 700);
      step(); chk("tc_timeout", FL, 0, 0);
      // CC+CV shared timer
      goto_cc();
      drive(1, 1, 700, 100, 500, 8);
      repeat (4) step();
      chk("cv_entry", CV, 450, 700);
      repeat (196) step();
      chk("chg_t200", CV, 450, 700);
      step(); chk("chg_timeout", FL, 0, 0);
      // DONE followed by a vbat sag
      goto_cc();
      drive(1, 1, 700, 100, 500, 8);
      repeat (4) step();
      drive(1, 1, 700, 28, 500, 8);
      repeat (4) step();
      chk("done", DN, 0, 0);
      drive(1, 1, 600, 28, 500, 8);
      repeat (3) step();
      chk("done_sag3", DN, 0, 0);
      step();
`ifdef BATCHG_RECHARGE_EN
      chk("recharge", CC, 450, 700);
`else
      chk("done_terminal", DN, 0, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
